fifo_bram_capture: RTL and testbench

//  Drains a frame of 36-bit complex samples ([35:18] real, [17:0] imag) from the 512-deep sample FIFO
//  and writes them sequentially into a 512-word capture BRAM (port A, write side).

---
 rtl/fifo_bram_capture_pkg.sv | 23 ++
 rtl/fifo_bram_capture_if.sv | 38 +++
 rtl/fifo_bram_capture.sv | 118 +++++++++++
 tb/tb_fifo_bram_capture.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bram_capture_pkg.sv
// Shared constants and types for the FIFO-to-BRAM frame capture block.
// Samples are packed complex values: real part in the upper half, imaginary part in the lower half.
package fifo_bram_capture_pkg;

   localparam int SAMPLE_W      = 36;
   localparam int RE_W          = 18;
   localparam int IM_W          = 18;
   localparam int FRAME_ADDR_W  = 9;
   localparam int CAP_FRAME_LEN = 512;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } cap_state_t;

   function automatic logic [SAMPLE_W-1:0] make_sample(input logic [RE_W-1:0] re,
                                                      input logic [IM_W-1:0] im);
      return {re, im};
   endfunction

endpackage

// File: rtl/fifo_bram_capture_if.sv
// Bundles the FIFO read side and the BRAM port-A write side of the capture block.
// master = capture engine, slave = FIFO/BRAM environment.
interface fifo_bram_capture_if
   import fifo_bram_capture_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int ADDR_W = FRAME_ADDR_W
);

   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd_en;
   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en,
      output bram_en,
      output bram_we,
      output bram_addr,
      output bram_din
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en,
      input  bram_en,
      input  bram_we,
      input  bram_addr,
      input  bram_din
   );

endinterface

// File: rtl/fifo_bram_capture.sv
// Drains one frame of samples from a standard (non-FWFT) FIFO into sequential BRAM addresses.
// Read strobe -> data valid -> registered BRAM write gives a two-clock read-to-write latency.
module fifo_bram_capture
   import fifo_bram_capture_pkg::*;
#(
   parameter int DATA_W    = SAMPLE_W,
   parameter int ADDR_W    = FRAME_ADDR_W,
   parameter int FRAME_LEN = CAP_FRAME_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   fifo_bram_capture_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count
);

   localparam logic [ADDR_W:0] LEN_CNT = (ADDR_W+1)'(FRAME_LEN);

   cap_state_t        state_reg;
   cap_state_t        state_next;
   logic [ADDR_W:0]   rd_issued_reg;
   logic [ADDR_W:0]   wr_count_reg;
   logic              rd_vld_reg;
   logic              bram_en_reg;
   logic              bram_we_reg;
   logic [ADDR_W-1:0] bram_addr_reg;
   logic [DATA_W-1:0] bram_din_reg;
   logic              rd_en;
   logic              start_ok;
   logic              capture;

   assign start_ok = (state_reg == S_IDLE) && start && !abort;
   // Abort kills the sample whose data is arriving this cycle, so nothing lands in BRAM.
   assign capture  = rd_vld_reg && !abort;

   always_comb begin
      state_next = state_reg;
      rd_en      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start_ok) state_next = S_RUN;
         end
         S_RUN: begin
            busy  = 1'b1;
            rd_en = !abort && !bus.fifo_empty && (rd_issued_reg < LEN_CNT);
            if (abort)
               state_next = S_IDLE;
            else if (rd_issued_reg == LEN_CNT)
               state_next = S_FLUSH;
         end
         S_FLUSH: begin
            busy = 1'b1;
            if (abort)
               state_next = S_IDLE;
            else if (wr_count_reg == LEN_CNT)
               state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_issued_reg <= '0;
         wr_count_reg  <= '0;
         rd_vld_reg    <= 1'b0;
         bram_en_reg   <= 1'b0;
         bram_we_reg   <= 1'b0;
         bram_addr_reg <= '0;
         bram_din_reg  <= '0;
      end else begin
         rd_vld_reg  <= rd_en;
         bram_en_reg <= capture;
         bram_we_reg <= capture;
         if (start_ok) begin
            rd_issued_reg <= '0;
            wr_count_reg  <= '0;
            bram_addr_reg <= '0;
         end else begin
            if (rd_en) begin
               rd_issued_reg <= rd_issued_reg + 1'b1;
            end
            if (capture) begin
               bram_addr_reg <= wr_count_reg[ADDR_W-1:0];
               bram_din_reg  <= bus.fifo_dout;
               wr_count_reg  <= wr_count_reg + 1'b1;
            end
         end
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.bram_en    = bram_en_reg;
   assign bus.bram_we    = bram_we_reg;
   assign bus.bram_addr  = bram_addr_reg;
   assign bus.bram_din   = bram_din_reg;
   assign wr_count       = wr_count_reg;

endmodule

// File: tb/tb_fifo_bram_capture.sv
// Bench for fifo_bram_capture: a 512-sample and a 16-sample instance, each fed by a behavioural
// non-FWFT FIFO; BRAM writes are matched against a queue of expected {addr, data} pairs.
`timescale 1ns/1ps
module tb_fifo_bram_capture;
   import fifo_bram_capture_pkg::*;

   localparam int DW   = SAMPLE_W;
   localparam int AW   = FRAME_ADDR_W;
   localparam int LEN0 = CAP_FRAME_LEN;
   localparam int LEN1 = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start_s    [2];
   logic          abort_s    [2];
   logic          busy_s     [2];
   logic          done_s     [2];
   logic [AW:0]   wr_count_s [2];
   logic          empty_s    [2];
   logic [DW-1:0] dout_s     [2];
   logic          rd_en_s    [2];
   logic          en_s       [2];
   logic          we_s       [2];
   logic [AW-1:0] addr_s     [2];
   logic [DW-1:0] din_s      [2];

   logic [DW-1:0] fmem [2][2048];
   logic [15:0]   wp [2] = '{16'd0, 16'd0};
   logic [15:0]   rp [2] = '{16'd0, 16'd0};

   fifo_bram_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   fifo_bram_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   assign empty_s[0]     = (wp[0] == rp[0]);
   assign empty_s[1]     = (wp[1] == rp[1]);
   assign bus0.fifo_empty = empty_s[0];
   assign bus1.fifo_empty = empty_s[1];
   assign bus0.fifo_dout  = dout_s[0];
   assign bus1.fifo_dout  = dout_s[1];
   assign rd_en_s[0] = bus0.fifo_rd_en;
   assign rd_en_s[1] = bus1.fifo_rd_en;
   assign en_s[0]    = bus0.bram_en;
   assign en_s[1]    = bus1.bram_en;
   assign we_s[0]    = bus0.bram_we;
   assign we_s[1]    = bus1.bram_we;
   assign addr_s[0]  = bus0.bram_addr;
   assign addr_s[1]  = bus1.bram_addr;
   assign din_s[0]   = bus0.bram_din;
   assign din_s[1]   = bus1.bram_din;

   fifo_bram_capture #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(LEN0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .bus(bus0),
      .busy(busy_s[0]), .done(done_s[0]), .wr_count(wr_count_s[0])
   );

   fifo_bram_capture #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(LEN1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .bus(bus1),
      .busy(busy_s[1]), .done(done_s[1]), .wr_count(wr_count_s[1])
   );

   // Standard FIFO: data appears on dout the clock after the read strobe.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rd_en_s[i] === 1'b1) begin
            dout_s[i] <= fmem[i][rp[i][10:0]];
            rp[i]     <= rp[i] + 16'd1;
         end
      end
   end

   int tests_run    = 0;
   int tests_failed = 0;
   int viol         = 0;
   int rd_cnt [2]   = '{0, 0};

   always @(negedge clk) begin
      #2;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n || (start_s[i] && !busy_s[i] && !done_s[i])) begin
            rd_cnt[i] = 0;
         end else if (rd_en_s[i] === 1'b1) begin
            if (empty_s[i]) viol++;
            rd_cnt[i]++;
            if (rd_cnt[i] > ((i == 0) ? LEN0 : LEN1)) viol++;
         end
         if (we_s[i] === 1'b1 && en_s[i] !== 1'b1) viol++;
      end
   end

   logic [AW+DW-1:0] exp_q [$];
   int sb_cyc, sb_writes, sb_bad, sb_dones, sb_done_cyc, sb_first_wr, sb_last_wr;
   logic [AW+DW-1:0] sb_act, sb_exp;

   task automatic sb_clear();
      exp_q.delete();
      sb_cyc = 0; sb_writes = 0; sb_bad = 0; sb_dones = 0;
      sb_done_cyc = -1; sb_first_wr = -1; sb_last_wr = -1;
      sb_act = '0; sb_exp = '0;
   endtask

   task automatic fifo_flush(input int i);
      wp[i] = rp[i];
   endtask

   task automatic push_word(input int i, input int k, input bit expect_it);
      logic [17:0] kv;
      kv = 18'(k);
      fmem[i][wp[i][10:0]] = make_sample(kv, ~kv);
      wp[i] = wp[i] + 16'd1;
      if (expect_it) exp_q.push_back({kv[AW-1:0], make_sample(kv, ~kv)});
   endtask

   task automatic sb_step(input int i);
      logic [AW+DW-1:0] got, want;
      if (we_s[i] === 1'b1) begin
         got = {addr_s[i], din_s[i]};
         sb_writes++;
         if (sb_first_wr < 0) sb_first_wr = sb_cyc;
         sb_last_wr = sb_cyc;
         if (exp_q.size() == 0) want = 'x;
         else want = exp_q.pop_front();
         if (got !== want) begin
            if (sb_bad == 0) begin sb_act = got; sb_exp = want; end
            sb_bad++;
         end
      end
      if (done_s[i] === 1'b1) begin
         sb_dones++;
         sb_done_cyc = sb_cyc;
      end
   endtask

   task automatic tick(input int i);
      @(posedge clk);
      sb_cyc++;
      @(negedge clk);
      sb_step(i);
   endtask

   task automatic test_reset();
      logic [DW+AW+AW+5:0] outs;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         outs = {rd_en_s[i], en_s[i], we_s[i], busy_s[i], done_s[i], addr_s[i], din_s[i], wr_count_s[i]};
         tests_run++;
         if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs inst%0d: got %h expected 0", i, outs);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("[TB] test_reset done");
   endtask

   task automatic test_full_frame();
      sb_clear();
      fifo_flush(0);
      for (int k = 0; k < LEN0; k++) push_word(0, k, 1'b1);
      start_s[0] = 1'b1;
      tick(0);
      start_s[0] = 1'b0;
      tests_run++;
      if (busy_s[0] !== 1'b1) begin
         tests_failed++; $display("FAIL full_busy_start: got %b expected 1", busy_s[0]);
      end
      while (sb_dones == 0 && sb_cyc < 600) tick(0);
      repeat (4) tick(0);
      tests_run++;
      if (sb_bad !== 0) begin
         tests_failed++; $display("FAIL full_data: %0d bad, got %h expected %h", sb_bad, sb_act, sb_exp);
      end
      tests_run++;
      if (sb_writes !== LEN0) begin
         tests_failed++; $display("FAIL full_writes: got %0d expected %0d", sb_writes, LEN0);
      end
      tests_run++;
      if (sb_first_wr !== 3) begin
         tests_failed++; $display("FAIL full_first_write_cycle: got %0d expected 3", sb_first_wr);
      end
      tests_run++;
      if (sb_last_wr - sb_first_wr !== LEN0 - 1) begin
         tests_failed++; $display("FAIL full_back_to_back: got span %0d expected %0d", sb_last_wr - sb_first_wr, LEN0 - 1);
      end
      tests_run++;
      if (sb_dones !== 1) begin
         tests_failed++; $display("FAIL full_done_count: got %0d expected 1", sb_dones);
      end
      tests_run++;
      if (sb_done_cyc !== LEN0 + 3) begin
         tests_failed++; $display("FAIL full_done_cycle: got %0d expected %0d", sb_done_cyc, LEN0 + 3);
      end
      tests_run++;
      if (wr_count_s[0] !== (AW+1)'(LEN0)) begin
         tests_failed++; $display("FAIL full_wr_count: got %0d expected %0d", wr_count_s[0], LEN0);
      end
      tests_run++;
      if (busy_s[0] !== 1'b0) begin
         tests_failed++; $display("FAIL full_busy_end: got %b expected 0", busy_s[0]);
      end
      $display("[TB] test_full_frame: writes=%0d done_cycle=%0d", sb_writes, sb_done_cyc);
   endtask

   task automatic test_slow_feed();
      logic [15:0] r0;
      int pushed;
      sb_clear();
      fifo_flush(1);
      r0 = rp[1];
      pushed = 0;
      start_s[1] = 1'b1;
      tick(1);
      start_s[1] = 1'b0;
      while (sb_dones == 0 && sb_cyc < 200) begin
         if ((sb_cyc % 3) == 1 && pushed < LEN1) begin
            push_word(1, pushed, 1'b1);
            pushed++;
         end
         tick(1);
      end
      repeat (5) tick(1);
      tests_run++;
      if (sb_bad !== 0) begin
         tests_failed++; $display("FAIL slow_data: %0d bad, got %h expected %h", sb_bad, sb_act, sb_exp);
      end
      tests_run++;
      if (sb_writes !== LEN1) begin
         tests_failed++; $display("FAIL slow_writes: got %0d expected %0d", sb_writes, LEN1);
      end
      tests_run++;
      if (sb_dones !== 1) begin
         tests_failed++; $display("FAIL slow_done_count: got %0d expected 1", sb_dones);
      end
      tests_run++;
      if (wr_count_s[1] !== (AW+1)'(LEN1)) begin
         tests_failed++; $display("FAIL slow_wr_count: got %0d expected %0d", wr_count_s[1], LEN1);
      end
      tests_run++;
      if (16'(rp[1] - r0) !== 16'(LEN1)) begin
         tests_failed++; $display("FAIL slow_reads: got %0d expected %0d", 16'(rp[1] - r0), LEN1);
      end
      $display("[TB] test_slow_feed: writes=%0d done_cycle=%0d", sb_writes, sb_done_cyc);
   endtask

   task automatic test_abort();
      sb_clear();
      fifo_flush(0);
      for (int k = 0; k < LEN0; k++) push_word(0, k, 1'b1);
      start_s[0] = 1'b1;
      tick(0);
      start_s[0] = 1'b0;
      while (sb_writes < 100 && sb_cyc < 400) tick(0);
      abort_s[0] = 1'b1;
      tick(0);
      abort_s[0] = 1'b0;
      tests_run++;
      if ({busy_s[0], rd_en_s[0]} !== 2'b00) begin
         tests_failed++; $display("FAIL abort_idle: got busy/rd_en %b%b expected 00", busy_s[0], rd_en_s[0]);
      end
      repeat (20) tick(0);
      tests_run++;
      if (sb_writes !== 100) begin
         tests_failed++; $display("FAIL abort_writes: got %0d expected 100", sb_writes);
      end
      tests_run++;
      if (sb_dones !== 0) begin
         tests_failed++; $display("FAIL abort_done: got %0d pulses expected 0", sb_dones);
      end
      tests_run++;
      if (wr_count_s[0] < (AW+1)'(100) || wr_count_s[0] > (AW+1)'(102)) begin
         tests_failed++; $display("FAIL abort_wr_count: got %0d expected 100..102", wr_count_s[0]);
      end
      tests_run++;
      if (sb_bad !== 0) begin
         tests_failed++; $display("FAIL abort_data: %0d bad, got %h expected %h", sb_bad, sb_act, sb_exp);
      end
      fifo_flush(0);
      $display("[TB] test_abort: writes=%0d wr_count=%0d", sb_writes, wr_count_s[0]);
   endtask

   task automatic test_restart_ignored();
      logic [15:0] r0;
      sb_clear();
      fifo_flush(0);
      r0 = rp[0];
      for (int k = 0; k < LEN0; k++) push_word(0, k, 1'b1);
      for (int k = LEN0; k < LEN0 + 20; k++) push_word(0, k, 1'b0);
      start_s[0] = 1'b1;
      tick(0);
      while (sb_cyc < 560) begin
         start_s[0] = (sb_cyc == 100) || (done_s[0] === 1'b1);
         tick(0);
      end
      start_s[0] = 1'b0;
      tests_run++;
      if (sb_bad !== 0) begin
         tests_failed++; $display("FAIL restart_data: %0d bad, got %h expected %h", sb_bad, sb_act, sb_exp);
      end
      tests_run++;
      if (sb_writes !== LEN0) begin
         tests_failed++; $display("FAIL restart_writes: got %0d expected %0d", sb_writes, LEN0);
      end
      tests_run++;
      if (sb_dones !== 1) begin
         tests_failed++; $display("FAIL restart_done_count: got %0d expected 1", sb_dones);
      end
      tests_run++;
      if (16'(rp[0] - r0) !== 16'(LEN0)) begin
         tests_failed++; $display("FAIL restart_reads: got %0d expected %0d", 16'(rp[0] - r0), LEN0);
      end
      tests_run++;
      if (busy_s[0] !== 1'b0) begin
         tests_failed++; $display("FAIL restart_busy: got %b expected 0", busy_s[0]);
      end
      fifo_flush(0);
      $display("[TB] test_restart_ignored: writes=%0d dones=%0d", sb_writes, sb_dones);
   endtask

   task automatic test_async_reset();
      logic [DW+AW+AW+5:0] outs;
      sb_clear();
      fifo_flush(0);
      for (int k = 0; k < LEN0; k++) push_word(0, k, 1'b1);
      start_s[0] = 1'b1;
      tick(0);
      start_s[0] = 1'b0;
      while (sb_writes < 200 && sb_cyc < 400) tick(0);
      rst_n = 1'b0;
      #1;
      outs = {rd_en_s[0], en_s[0], we_s[0], busy_s[0], done_s[0], addr_s[0], din_s[0], wr_count_s[0]};
      tests_run++;
      if (outs !== '0) begin
         tests_failed++; $display("FAIL async_reset_outputs: got %h expected 0", outs);
      end
      fifo_flush(0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sb_clear();
      for (int k = 0; k < LEN1; k++) push_word(0, k, 1'b1);
      start_s[0] = 1'b1;
      tick(0);
      start_s[0] = 1'b0;
      repeat (30) tick(0);
      tests_run++;
      if (sb_bad !== 0) begin
         tests_failed++; $display("FAIL reset_restart_data: %0d bad, got %h expected %h", sb_bad, sb_act, sb_exp);
      end
      tests_run++;
      if (sb_writes !== LEN1) begin
         tests_failed++; $display("FAIL reset_restart_writes: got %0d expected %0d", sb_writes, LEN1);
      end
      tests_run++;
      if (sb_first_wr !== 3) begin
         tests_failed++; $display("FAIL reset_restart_latency: got %0d expected 3", sb_first_wr);
      end
      tests_run++;
      if (busy_s[0] !== 1'b1) begin
         tests_failed++; $display("FAIL reset_restart_busy: got %b expected 1", busy_s[0]);
      end
      abort_s[0] = 1'b1;
      tick(0);
      abort_s[0] = 1'b0;
      tests_run++;
      if (busy_s[0] !== 1'b0) begin
         tests_failed++; $display("FAIL reset_cleanup_abort: got busy %b expected 0", busy_s[0]);
      end
      fifo_flush(0);
      $display("[TB] test_async_reset: restart writes=%0d", sb_writes);
   endtask

   task automatic test_start_abort();
      logic [15:0] r0;
      sb_clear();
      fifo_flush(1);
      r0 = rp[1];
      for (int k = 0; k < 4; k++) push_word(1, k, 1'b0);
      start_s[1] = 1'b1;
      abort_s[1] = 1'b1;
      tick(1);
      start_s[1] = 1'b0;
      abort_s[1] = 1'b0;
      repeat (4) tick(1);
      tests_run++;
      if (busy_s[1] !== 1'b0) begin
         tests_failed++; $display("FAIL start_abort_busy: got %b expected 0", busy_s[1]);
      end
      tests_run++;
      if (rp[1] !== r0 || sb_writes !== 0) begin
         tests_failed++; $display("FAIL start_abort_activity: got reads %0d writes %0d expected 0 0", 16'(rp[1] - r0), sb_writes);
      end
      fifo_flush(1);
      $display("[TB] test_start_abort: reads=%0d", 16'(rp[1] - r0));
   endtask

   task automatic test_invariants();
      tests_run++;
      if (viol !== 0) begin
         tests_failed++; $display("FAIL invariants: got %0d violations expected 0", viol);
      end
      $display("[TB] test_invariants: violations=%0d", viol);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         abort_s[i] = 1'b0;
      end
      rst_n = 1'b0;
      test_reset();
      test_full_frame();
      test_slow_feed();
      test_abort();
      test_restart_ignored();
      test_async_reset();
      test_start_abort();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
      $fatal(1, "watchdog expired");
   end

endmodule
